// File: rtl/instr_buffer_ctrl.sv
// rtl/instr_buffer_ctrl.sv - fill/drain sequencer for a passive instruction buffer
// Optional multi-pass drain enabled by defining IBC_REPEAT_EN.
module instr_buffer_ctrl #(
    parameter int IW = 32,
    parameter int BS = 16,
    localparam int AW = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef IBC_REPEAT_EN
    input  logic [7:0]    repeat_cnt,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic          abort,
    output logic [AW-1:0] buf_idx,
    output logic          buf_we,
    output logic [IW-1:0] buf_wdata,
    input  logic [IW-1:0] buf_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_idx,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE} state_t;

    localparam logic [AW:0] LAST_SLOT = (AW+1)'(BS - 1);
    localparam logic [AW:0] ONE       = (AW+1)'(1);

    state_t        state, state_nx;
    logic [AW:0]   cnt_q;
    // rd_cnt carries one extra bit so a full buffer is distinguishable from empty
    logic [AW:0]   rd_cnt;
    logic [AW:0]   rd_eff;
    logic          out_valid_q;
    logic [IW-1:0] out_instr_q;
    logic [AW-1:0] out_idx_q;
    logic          more;
    logic          wrap;
    logic          wrap_ok;
    logic          load;

`ifdef IBC_REPEAT_EN
    logic [7:0]    rep_left;
    assign wrap_ok = (rep_left != 8'd0);
`else
    assign wrap_ok = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        buf_we    = 1'b0;
        buf_idx   = '0;
        buf_wdata = '0;
        more      = 1'b0;
        wrap      = 1'b0;
        rd_eff    = rd_cnt;
        load      = 1'b0;
        case (state)
            S_FILL: begin
                in_ready  = 1'b1;
                buf_idx   = cnt_q[AW-1:0];
                buf_wdata = in_instr;
                buf_we    = in_valid && (in_instr != '0) && !abort;
                if (in_valid) begin
                    if (in_instr != '0) begin
                        if (cnt_q == LAST_SLOT)
                            state_nx = S_DRAIN;
                    end else begin
                        state_nx = (cnt_q != '0) ? S_DRAIN : S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                more    = (rd_cnt != cnt_q);
                // Restart the pass in the same cycle the last entry goes out
                wrap    = !more && wrap_ok;
                rd_eff  = wrap ? '0 : rd_cnt;
                buf_idx = rd_eff[AW-1:0];
                load    = (more || wrap) && (!out_valid_q || out_ready);
                if (out_valid_q && out_ready && !more && !wrap)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_FILL;
            end
            default: state_nx = S_FILL;
        endcase
        if (abort)
            state_nx = S_FILL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FILL;
            cnt_q       <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_idx_q   <= '0;
`ifdef IBC_REPEAT_EN
            rep_left    <= 8'd0;
`endif
        end else begin
            state <= state_nx;
            if (abort) begin
                cnt_q       <= '0;
                rd_cnt      <= '0;
                out_valid_q <= 1'b0;
`ifdef IBC_REPEAT_EN
                rep_left    <= 8'd0;
`endif
            end else begin
                case (state)
                    S_FILL: begin
                        if (in_valid && (in_instr != '0))
                            cnt_q <= cnt_q + ONE;
`ifdef IBC_REPEAT_EN
                        if (state_nx == S_DRAIN)
                            rep_left <= repeat_cnt;
`endif
                    end
                    S_DRAIN: begin
                        if (load) begin
                            out_instr_q <= buf_rdata;
                            out_idx_q   <= rd_eff[AW-1:0];
                            rd_cnt      <= rd_eff + ONE;
                            out_valid_q <= 1'b1;
`ifdef IBC_REPEAT_EN
                            if (wrap)
                                rep_left <= rep_left - 8'd1;
`endif
                        end else if (out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        cnt_q  <= '0;
                        rd_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_idx   = out_idx_q;
    assign count     = cnt_q;
    assign busy      = (state != S_FILL);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_instr_buffer_ctrl.sv
// tb/tb_instr_buffer_ctrl.sv - directed self-checking bench for instr_buffer_ctrl
module tb_instr_buffer_ctrl;

    localparam int IW = 32;
    localparam int BS = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_instr = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] buf_idx;
    logic          buf_we;
    logic [IW-1:0] buf_wdata;
    logic [IW-1:0] buf_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_idx;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
`ifdef IBC_REPEAT_EN
    logic [7:0]    repeat_cnt = 8'd0;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [IW-1:0]    mem [BS];
    logic [AW+IW-1:0] got[$];
    int               got_cyc[$];
    int               n_done;

    always #5 clk = ~clk;

    always @(posedge clk) if (buf_we) mem[buf_idx] <= buf_wdata;
    assign buf_rdata = mem[buf_idx];

    instr_buffer_ctrl #(.IW(IW), .BS(BS)) dut (
        .clk(clk), .rst(rst),
`ifdef IBC_REPEAT_EN
        .repeat_cnt(repeat_cnt),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .abort(abort),
        .buf_idx(buf_idx), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_idx(out_idx),
        .count(count), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [IW-1:0] w);
        in_valid = 1'b1;
        in_instr = w;
        tick();
        in_valid = 1'b0;
        in_instr = '0;
    endtask

    task automatic run_drain(input int max_cyc);
        got.delete();
        got_cyc.delete();
        n_done = 0;
        out_ready = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got.push_back({out_idx, out_instr});
                got_cyc.push_back(c);
            end
            if (done) begin
                n_done++;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        logic [IW+2*AW+6:0] obs, exp;
        rst = 1'b1;
        #1;
        obs = {in_ready, out_valid, busy, done, buf_we, count, buf_idx, out_idx, out_instr};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 32'd0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp %h", obs, exp);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [IW-1:0] words [3];
        words[0] = 32'hA1; words[1] = 32'hA2; words[2] = 32'hA3;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = words[i];
            @(negedge clk);
            vectors++;
            if ({buf_we, buf_idx} !== {1'b1, 4'(i)}) begin
                miscompares++;
                $display("FAIL basic_write%0d got we=%b idx=%0d exp we=1 idx=%0d", i, buf_we, buf_idx, i);
            end
            tick();
        end
        in_instr = '0;
        @(negedge clk);
        vectors++;
        if (buf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_term_we got %b exp 0", buf_we);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({count, busy, in_ready, out_valid} !== {5'd3, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_drain_entry got cnt=%0d busy=%b rdy=%b ov=%b exp 3 1 0 0",
                     count, busy, in_ready, out_valid);
        end
        run_drain(20);
        vectors++;
        if (got.size() !== 3 || n_done !== 1) begin
            miscompares++;
            $display("FAIL basic_drain_len got n=%0d done=%0d exp 3 1", got.size(), n_done);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got[i] !== {4'(i), words[i]} || got_cyc[i] !== got_cyc[0] + i) begin
                    miscompares++;
                    $display("FAIL basic_out%0d got %h @%0d exp %h @%0d", i, got[i], got_cyc[i],
                             {4'(i), words[i]}, got_cyc[0] + i);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if ({in_ready, busy, done, count} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL basic_back_to_fill got rdy=%b busy=%b done=%b cnt=%0d exp 1 0 0 0",
                     in_ready, busy, done, count);
        end
        tick();
    endtask

    task automatic test_full();
        for (int k = 0; k < BS; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h100 + k;
            @(negedge clk);
            vectors++;
            if ({in_ready, buf_we, buf_idx} !== {1'b1, 1'b1, 4'(k)}) begin
                miscompares++;
                $display("FAIL full_write%0d got rdy=%b we=%b idx=%0d exp 1 1 %0d",
                         k, in_ready, buf_we, buf_idx, k);
            end
            tick();
        end
        in_instr = '0;
        @(negedge clk);
        vectors++;
        if ({in_ready, count} !== {1'b0, 5'd16}) begin
            miscompares++;
            $display("FAIL full_stop got rdy=%b cnt=%0d exp 0 16", in_ready, count);
        end
        tick();
        run_drain(60);
        vectors++;
        if (got.size() !== BS || n_done !== 1) begin
            miscompares++;
            $display("FAIL full_drain_len got n=%0d done=%0d exp 16 1", got.size(), n_done);
        end else begin
            for (int k = 0; k < BS; k++) begin
                vectors++;
                if (got[k] !== {4'(k), 32'h100 + k}) begin
                    miscompares++;
                    $display("FAIL full_out%0d got %h exp %h", k, got[k], {4'(k), 32'h100 + k});
                end
            end
        end
        // the zero held on the input is now taken as an empty program
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_refill_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL full_late_zero_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_immediate_zero();
        int seen_ov = 0;
        int seen_done = 0;
        in_valid = 1'b1;
        in_instr = '0;
        @(negedge clk);
        vectors++;
        if (buf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_we got %b exp 0", buf_we);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_done got %b exp 1", done);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            if (out_valid) seen_ov++;
            if (done) seen_done++;
        end
        vectors++;
        if ({seen_ov, seen_done} !== {32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL zero_quiet got ov=%0d done=%0d exp 0 0", seen_ov, seen_done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int stall = 0;
        logic [IW-1:0] held_i;
        logic [AW-1:0] held_x;
        logic ended = 1'b0;
        for (int i = 0; i < 6; i++) fill(32'hC1 + i);
        fill('0);
        got.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                if (stall > 0) begin
                    vectors++;
                    if ({out_instr, out_idx} !== {held_i, held_x}) begin
                        miscompares++;
                        $display("FAIL bp_stable got %h/%0d exp %h/%0d", out_instr, out_idx, held_i, held_x);
                    end
                end
                held_i = out_instr;
                held_x = out_idx;
                stall++;
            end
            if (out_valid && out_ready) got.push_back({out_idx, out_instr});
            if (done) begin
                ended = 1'b1;
                break;
            end
            tick();
            out_ready = !(got.size() == 2 && stall < 4);
        end
        vectors++;
        if (!ended || stall !== 4 || got.size() !== 6) begin
            miscompares++;
            $display("FAIL bp_summary got end=%b stalls=%0d n=%0d exp 1 4 6", ended, stall, got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (got[i] !== {4'(i), 32'hC1 + i}) begin
                    miscompares++;
                    $display("FAIL bp_out%0d got %h exp %h", i, got[i], {4'(i), 32'hC1 + i});
                end
            end
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        int acc = 0;
        int seen_done = 0;
        for (int i = 0; i < 5; i++) fill(32'hD1 + i);
        fill('0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) acc++;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        vectors++;
        if ({acc, out_valid, in_ready, busy, done, count} !== {32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL abort_state got acc=%0d ov=%b rdy=%b busy=%b done=%b cnt=%0d exp 2 0 1 0 0 0",
                     acc, out_valid, in_ready, busy, done, count);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            if (done) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done got %0d pulses exp 0", seen_done);
        end
        tick();
        in_valid = 1'b1;
        in_instr = 32'hE0;
        abort = 1'b1;
        @(negedge clk);
        vectors++;
        if (buf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_fill_we got %b exp 0", buf_we);
        end
        tick();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_instr = 32'hE1 + i;
            @(negedge clk);
            vectors++;
            if ({buf_we, buf_idx} !== {1'b1, 4'(i)}) begin
                miscompares++;
                $display("FAIL abort_refill%0d got we=%b idx=%0d exp 1 %0d", i, buf_we, buf_idx, i);
            end
            tick();
        end
        in_instr = '0;
        tick();
        in_valid = 1'b0;
        run_drain(20);
        vectors++;
        if (got.size() !== 2 || n_done !== 1 || got[0] !== {4'd0, 32'hE1} || got[1] !== {4'd1, 32'hE2}) begin
            miscompares++;
            $display("FAIL abort_refill_drain got n=%0d done=%0d exp E1,E2 with one done", got.size(), n_done);
        end
    endtask

    task automatic test_reset_async();
        fill(32'hF1);
        fill(32'hF2);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, buf_idx, count, out_valid, busy, done} !== {1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_midfill got rdy=%b idx=%0d cnt=%0d ov=%b busy=%b done=%b exp 1 0 0 0 0 0",
                     in_ready, buf_idx, count, out_valid, busy, done);
        end
        tick();
        rst = 1'b0;
        fill(32'hF3);
        fill('0);
        out_ready = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, busy, in_ready, out_instr} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL rst_middrain got ov=%b busy=%b rdy=%b instr=%h exp 0 0 1 0",
                     out_valid, busy, in_ready, out_instr);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

`ifdef IBC_REPEAT_EN
    task automatic test_repeat();
        logic [IW-1:0] seq [6];
        repeat_cnt = 8'd2;
        fill(32'hB1);
        fill(32'hB2);
        fill('0);
        repeat_cnt = 8'd0;
        run_drain(40);
        for (int i = 0; i < 6; i++) seq[i] = (i % 2 == 0) ? 32'hB1 : 32'hB2;
        vectors++;
        if (got.size() !== 6 || n_done !== 1) begin
            miscompares++;
            $display("FAIL repeat_len got n=%0d done=%0d exp 6 1", got.size(), n_done);
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (got[i][IW-1:0] !== seq[i] || got_cyc[i] !== got_cyc[0] + i) begin
                    miscompares++;
                    $display("FAIL repeat_out%0d got %h @%0d exp %h @%0d", i, got[i][IW-1:0],
                             got_cyc[i], seq[i], got_cyc[0] + i);
                end
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < BS; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_full();
        test_immediate_zero();
        test_backpressure();
        test_abort();
        test_reset_async();
`ifdef IBC_REPEAT_EN
        test_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
